clk_dist_ctrl: RTL and testbench
================================

# clk_dist_ctrl

Sequencer for the clock distribution block (x1 / x2 / div2 / div4 clock generator with doubler DLL). Accepts mode-change requests over a valid/ready handshake and drives `clk_en` and `mode_sel` glitch-safely: `mode_sel` changes only while `clk_en` is low. In x2 mode it waits for DLL lock, with a timeout. Sits in the digital control domain between the register interface and the analog clock block.

## Interface
- `SETTLE_CYC`, default 8: cycles `clk_en` stays low before and after a `mode_sel` update (≥2).
- `LOCK_TIMEOUT`, default 1024: cycles allowed for synchronized `dll_locked` to rise in x2 mode.
- `MAX_RETRY`, default 2: extra lock attempts after a timeout (only with `CLK_DIST_CTRL_RETRY_EN`).
- `clk`  in  1  controller clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  1  mode-change request.
- `req_mode`  in  2  requested mode: 00 x1, 01 x2, 11 div2, 10 div4.
- `req_off`  in  1  with `req_valid`: request block off (`req_mode` ignored).
- `req_ready`  out  1  high only in IDLE and RUN.
- `dll_locked`  in  1  asynchronous lock flag from the clock block.
- `clk_en`  out  1  clock block enable.
- `mode_sel`  out  2  clock block mode select.
- `running`  out  1  high in RUN.
- `lock_err`  out  1  sticky; set on final lock timeout; cleared by the next accepted request.
- `lock_lost`  out  1  one-cycle pulse on a RUN-state x2 lock loss.

## Operation
- `dll_locked` passes through a 2-flop synchronizer, giving `lock_s`. All lock decisions use `lock_s`.
- A request is accepted when `req_valid && req_ready`. The controller latches mode and off in that cycle.
- States and transitions:
  - IDLE: `clk_en`=0. On accept with `req_off`=0, go to GATE. On accept with `req_off`=1, stay in IDLE (no-op).
  - GATE: `clk_en`=0. Count `SETTLE_CYC` cycles, then load `mode_sel` from the latched mode and go to SETTLE.
  - SETTLE: `clk_en`=0. Count `SETTLE_CYC` cycles, then go to ENABLE.
  - ENABLE: `clk_en`=1. Lasts one cycle. Go to LOCK_WAIT if mode is 01, else RUN.
  - LOCK_WAIT: `clk_en`=1. Go to RUN when `lock_s`=1. If the timeout counter reaches `LOCK_TIMEOUT`−1 without lock, go to FAIL.
  - RUN: `running`=1. On accept with `req_off`=1, go to IDLE (`clk_en` drops the next cycle). On accept of any other mode, go to GATE. Re-requesting the current mode still runs the full sequence.
  - FAIL: `clk_en`=0. Set `lock_err`, then go to IDLE the next cycle.
- Lock loss: in RUN with x2 mode, `lock_s` falling pulses `lock_lost` and goes to GATE to relock with the same mode. `running` drops.
- Counters are saturating, width `$clog2(max(SETTLE_CYC, LOCK_TIMEOUT))`. Each counter clears on every state entry.
- `mode_sel` changes only on the GATE→SETTLE edge. It holds its value through IDLE and FAIL.

## Timing
- Reset values: state=IDLE, `clk_en`=0, `mode_sel`=00, `req_ready`=1, `running`=0, `lock_err`=0, `lock_lost`=0. The synchronizer flops reset to 0.
- All outputs are registered.
- Latency from accept to `clk_en` rise is 2·`SETTLE_CYC`+2 cycles (non-x2 modes).
- In x2 mode, `running` rises 1 cycle after the `lock_s` rise. `lock_s` lags `dll_locked` by 2–3 cycles.
- `req_ready` drops in the cycle after an accept and rises on entry to RUN or IDLE.
- A request and a lock loss in the same RUN cycle: the request wins and `lock_lost` still pulses.
- Timeout boundary: lock arriving in the same cycle as the timeout terminal count counts as locked.
- `rst` mid-sequence forces all outputs to their reset values immediately (asynchronous), including `clk_en`=0.

## Configuration
- `CLK_DIST_CTRL_RETRY_EN` defined:
  - A lock timeout re-enters GATE with the same mode, up to `MAX_RETRY` times, and increments a retry counter.
  - FAIL is reached only when the last attempt times out.
  - The retry counter clears on accept.
- Not defined: the first timeout goes directly to FAIL and `MAX_RETRY` is unused.

## Structure
- Package `clk_dist_pkg` holds:
  - `typedef enum logic [1:0] clk_mode_e` (X1=00, X2=01, DIV4=10, DIV2=11);
  - the state enum `clk_dist_state_e`.
- One sub-module, `sync_2ff`: the 2-flop synchronizer for `dll_locked`, with async active-high reset.

## Test plan
- Reset, then request x1 with `SETTLE_CYC`=8 → `mode_sel`=00 loaded at cycle 9 after accept; `clk_en` rises at cycle 18; `running`=1 at cycle 19.
- Request x2; `dll_locked` rises 50 cycles after `clk_en` → `running` rises 3–4 cycles after `dll_locked`; `lock_err`=0.
- Request x2 with `dll_locked` held at 0 and the macro undefined → FAIL after 1024 cycles; `lock_err`=1; `clk_en`=0; `req_ready`=1.
- Same stimulus with the macro defined and `MAX_RETRY`=2 → three GATE sequences, then `lock_err`=1.
- Running x2, drop `dll_locked` → one-cycle `lock_lost`; `clk_en` falls; `mode_sel` stays 01; relock completes when `dll_locked` returns.
- Mode change div2→div4 in RUN → `clk_en` is low across the `mode_sel` change, with no cycle where `clk_en`=1 while `mode_sel` changes. Assert `rst` mid-SETTLE → `clk_en`=0 and `mode_sel`=00 immediately.

Source files
------------

// File: rtl/clk_dist_pkg.sv
// clk_dist_pkg: shared types for the clock distribution sequencer.
//   clk_mode_e       : mode_sel encoding driven to the analog clock block
//   clk_dist_state_e : sequencer state
//   max2()           : helper for sizing the shared cycle counter
package clk_dist_pkg;

    typedef enum logic [1:0] {
        X1   = 2'b00,
        X2   = 2'b01,
        DIV4 = 2'b10,
        DIV2 = 2'b11
    } clk_mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATE,
        S_SETTLE,
        S_ENABLE,
        S_LOCK_WAIT,
        S_RUN,
        S_FAIL
    } clk_dist_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_dist_ctrl_if.sv
// clk_dist_ctrl_if: mode-change request handshake.
//   req_valid : request present
//   req_mode  : requested clock mode
//   req_off   : request block off (req_mode ignored)
//   req_ready : sequencer can accept a request
// master drives the request, slave (the sequencer) returns ready.
interface clk_dist_ctrl_if;
    import clk_dist_pkg::*;

    logic      req_valid;
    clk_mode_e req_mode;
    logic      req_off;
    logic      req_ready;

    modport master (output req_valid, output req_mode, output req_off, input req_ready);
    modport slave  (input req_valid, input req_mode, input req_off, output req_ready);
endinterface

// File: rtl/clk_dist_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a slow asynchronous level.
//   clk, rst : destination clock, async active-high reset (output resets to 0)
//   d_i      : asynchronous input
//   q_o      : synchronized output, 2-3 cycles behind d_i
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end
endmodule

// File: rtl/clk_dist_ctrl.sv
// clk_dist_ctrl: sequencer for the x1/x2/div2/div4 clock block.
// Takes mode-change requests and drives clk_en/mode_sel so that mode_sel only
// moves while clk_en is low; in x2 mode waits (with timeout) for DLL lock.
//   clk, rst     : controller clock, async active-high reset
//   req          : request handshake (slave side)
//   dll_locked_i : asynchronous DLL lock flag
//   clk_en_o     : clock block enable
//   mode_sel_o   : clock block mode select
//   running_o    : sequence complete, clock live
//   lock_err_o   : sticky lock failure, cleared by next accepted request
//   lock_lost_o  : one-cycle pulse on lock loss while running x2
// Build option: CLK_DIST_CTRL_RETRY_EN retries lock up to MAX_RETRY times
// before failing; without it the first timeout fails.
module clk_dist_ctrl
    import clk_dist_pkg::*;
#(
    parameter int SETTLE_CYC   = 8,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int MAX_RETRY    = 2
) (
    input  logic             clk,
    input  logic             rst,
    clk_dist_ctrl_if.slave   req,
    input  logic             dll_locked_i,
    output logic             clk_en_o,
    output clk_mode_e        mode_sel_o,
    output logic             running_o,
    output logic             lock_err_o,
    output logic             lock_lost_o
);
    // One spare bit so the settle phase can reach SETTLE_CYC itself.
    localparam int CNT_W = $clog2(max2(SETTLE_CYC, LOCK_TIMEOUT)) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] GATE_END   = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] LOCK_END   = CNT_W'(LOCK_TIMEOUT - 1);

    clk_dist_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    clk_mode_e        mode_q, mode_d;
    clk_mode_e        mode_sel_q, mode_sel_d;
    logic             clk_en_q, clk_en_d;
    logic             ready_q, ready_d;
    logic             running_q, running_d;
    logic             lock_err_q, lock_err_d;
    logic             lock_lost_q, lock_lost_d;

    logic lock_s;
    logic accept;
    logic lock_to;
    logic retry_ok;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (dll_locked_i),
        .q_o (lock_s)
    );

    assign accept  = req.req_valid && ready_q;
    // Terminal count without lock; a lock in the same cycle wins.
    assign lock_to = (state_q == S_LOCK_WAIT) && !lock_s && (cnt_q == LOCK_END);

`ifdef CLK_DIST_CTRL_RETRY_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RTY_W-1:0] retry_q;

    assign retry_ok = int'(retry_q) < MAX_RETRY;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      retry_q <= '0;
        else if (accept)              retry_q <= '0;
        else if (lock_to && retry_ok) retry_q <= retry_q + 1'b1;
    end
`else
    logic unused_max_retry;
    assign unused_max_retry = (MAX_RETRY != 0);
    assign retry_ok         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        mode_sel_d  = mode_sel_q;
        lock_err_d  = lock_err_q;
        lock_lost_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    lock_err_d = 1'b0;
                    if (!req.req_off) begin
                        mode_d  = req.req_mode;
                        state_d = S_GATE;
                    end
                end
            end
            S_GATE: begin
                if (cnt_q == GATE_END) begin
                    mode_sel_d = mode_q;
                    state_d    = S_SETTLE;
                end
            end
            // Counts past the cycle mode_sel moves, so clk_en stays low for
            // SETTLE_CYC full cycles on either side of the update.
            S_SETTLE: if (cnt_q == SETTLE_END) state_d = S_ENABLE;
            S_ENABLE: state_d = (mode_q == X2) ? S_LOCK_WAIT : S_RUN;
            S_LOCK_WAIT: begin
                if (lock_s) begin
                    state_d = S_RUN;
                end else if (lock_to) begin
                    if (retry_ok) begin
                        state_d = S_GATE;
                    end else begin
                        state_d    = S_FAIL;
                        lock_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // Only x2 RUN is entered with lock_s high, so low here is a fall.
                if (mode_q == X2 && !lock_s) begin
                    lock_lost_d = 1'b1;
                    state_d     = S_GATE;
                end
                // A request overrides the relock target; the pulse above stays.
                if (accept) begin
                    lock_err_d = 1'b0;
                    if (req.req_off) begin
                        state_d = S_IDLE;
                    end else begin
                        mode_d  = req.req_mode;
                        state_d = S_GATE;
                    end
                end
            end
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else cnt_d = cnt_q + 1'b1;

        clk_en_d  = (state_d == S_ENABLE) || (state_d == S_LOCK_WAIT) || (state_d == S_RUN);
        ready_d   = (state_d == S_IDLE) || (state_d == S_RUN);
        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mode_q      <= X1;
            mode_sel_q  <= X1;
            clk_en_q    <= 1'b0;
            ready_q     <= 1'b1;
            running_q   <= 1'b0;
            lock_err_q  <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            mode_sel_q  <= mode_sel_d;
            clk_en_q    <= clk_en_d;
            ready_q     <= ready_d;
            running_q   <= running_d;
            lock_err_q  <= lock_err_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign req.req_ready = ready_q;
    assign clk_en_o      = clk_en_q;
    assign mode_sel_o    = mode_sel_q;
    assign running_o     = running_q;
    assign lock_err_o    = lock_err_q;
    assign lock_lost_o   = lock_lost_q;
endmodule

// File: tb/tb_clk_dist_ctrl.sv
// tb_clk_dist_ctrl: directed bench for clk_dist_ctrl. A vector table covers
// non-x2 mode changes and off requests; hand sequences cover latency, x2
// lock, lock loss, request/lock-loss collision, timeout and its boundary,
// and asynchronous reset. Honors CLK_DIST_CTRL_RETRY_EN for timeout counts.
module tb_clk_dist_ctrl;
    import clk_dist_pkg::*;

    localparam int S = 8;
    localparam int T = 1024;
    localparam int R = 2;
`ifdef CLK_DIST_CTRL_RETRY_EN
    localparam int ATTEMPTS = R + 1;
`else
    localparam int ATTEMPTS = 1;
`endif
    // Cycles from accept edge to the timeout edge of one lock attempt.
    localparam int ATTEMPT_LEN = 2 * S + 2 + T;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      dll = 1'b0;
    logic      clk_en, running, lock_err, lock_lost;
    clk_mode_e mode_sel;
    int        total = 0;
    int        bad   = 0;
    int        glitch = 0;

    clk_dist_ctrl_if bus();

    clk_dist_ctrl #(.SETTLE_CYC(S), .LOCK_TIMEOUT(T), .MAX_RETRY(R)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (bus),
        .dll_locked_i (dll),
        .clk_en_o     (clk_en),
        .mode_sel_o   (mode_sel),
        .running_o    (running),
        .lock_err_o   (lock_err),
        .lock_lost_o  (lock_lost)
    );

    always #5 clk = ~clk;

    // mode_sel must never move when clk_en is high before or after the edge.
    logic [1:0] prev_sel = 2'b00;
    logic       prev_en  = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!rst && (mode_sel != prev_sel) && (clk_en || prev_en)) glitch++;
        prev_sel = mode_sel;
        prev_en  = clk_en;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time=%0t limit=500000", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns one step after the accept edge.
    task automatic send(input clk_mode_e m, input logic off);
        bus.req_valid = 1'b1;
        bus.req_mode  = m;
        bus.req_off   = off;
        cyc();
        bus.req_valid = 1'b0;
    endtask

    typedef struct {
        clk_mode_e mode;
        logic      off;
        clk_mode_e sel;
        logic      run;
    } vec_t;

    vec_t vecs [7];
    int   n, t_sel, t_en, t_run, rises;
    logic pe;

    initial begin
        vecs[0] = '{mode: X1,   off: 1'b0, sel: X1,   run: 1'b1};
        vecs[1] = '{mode: DIV2, off: 1'b0, sel: DIV2, run: 1'b1};
        vecs[2] = '{mode: DIV4, off: 1'b0, sel: DIV4, run: 1'b1};
        vecs[3] = '{mode: DIV4, off: 1'b0, sel: DIV4, run: 1'b1};
        vecs[4] = '{mode: X1,   off: 1'b1, sel: DIV4, run: 1'b0};
        vecs[5] = '{mode: DIV2, off: 1'b1, sel: DIV4, run: 1'b0};
        vecs[6] = '{mode: DIV2, off: 1'b0, sel: DIV2, run: 1'b1};

        bus.req_valid = 1'b0;
        bus.req_mode  = X1;
        bus.req_off   = 1'b0;

        // Reset state
        repeat (3) cyc();
        chk("rst_clk_en", clk_en, 0);
        chk("rst_mode_sel", mode_sel, 0);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_running", running, 0);
        chk("rst_lock_err", lock_err, 0);
        chk("rst_lock_lost", lock_lost, 0);
        rst = 1'b0;
        cyc();

        // Latency from accept
        send(DIV2, 1'b0);
        chk("lat_ready_drop", bus.req_ready, 0);
        t_sel = 0; t_en = 0; t_run = 0;
        for (int k = 1; k <= 25; k++) begin
            if (t_sel == 0 && mode_sel == DIV2) t_sel = k;
            if (t_en == 0 && clk_en) t_en = k;
            if (t_run == 0 && running) t_run = k;
            cyc();
        end
        chk("lat_mode_sel", t_sel, S + 1);
        chk("lat_clk_en", t_en, 2 * S + 2);
        chk("lat_running", t_run, 2 * S + 3);

        // Vector table: non-x2 mode changes and off requests
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].mode, vecs[i].off);
            repeat (2 * S + 3) cyc();
            chk($sformatf("vec%0d_mode_sel", i), mode_sel, vecs[i].sel);
            chk($sformatf("vec%0d_running", i), running, vecs[i].run);
            chk($sformatf("vec%0d_clk_en", i), clk_en, vecs[i].run);
            chk($sformatf("vec%0d_ready", i), bus.req_ready, 1);
        end

        // x2 with lock arriving 50 cycles after enable
        send(X2, 1'b0);
        n = 0;
        while (!clk_en && n < 100) begin cyc(); n++; end
        chk("x2_clk_en", clk_en, 1);
        repeat (50) cyc();
        chk("x2_wait_not_running", running, 0);
        dll = 1'b1;
        n = 0;
        while (!running && n < 10) begin cyc(); n++; end
        chk("x2_run_lat_3to4", int'(n >= 3 && n <= 4), 1);
        chk("x2_lock_err", lock_err, 0);
        chk("x2_mode_sel", mode_sel, X2);

        // Lock loss in x2 RUN, then relock
        dll = 1'b0;
        n = 0;
        while (!lock_lost && n < 10) begin cyc(); n++; end
        chk("ll_lat_3to4", int'(n >= 3 && n <= 4), 1);
        chk("ll_clk_en", clk_en, 0);
        chk("ll_running", running, 0);
        chk("ll_mode_sel", mode_sel, X2);
        cyc();
        chk("ll_one_cycle", lock_lost, 0);
        dll = 1'b1;
        n = 0;
        while (!running && n < 40) begin cyc(); n++; end
        chk("relock_running", running, 1);
        chk("relock_clk_en", clk_en, 1);
        chk("relock_mode_sel", mode_sel, X2);

        // Request and lock loss in the same RUN cycle: request wins
        dll = 1'b0;
        cyc();
        cyc();
        send(DIV2, 1'b0);
        chk("both_lock_lost", lock_lost, 1);
        chk("both_ready", bus.req_ready, 0);
        repeat (2 * S + 3) cyc();
        chk("both_mode_sel", mode_sel, DIV2);
        chk("both_running", running, 1);

        // Lock timeout with dll held low
        send(X2, 1'b0);
        n = 1; rises = 0; pe = clk_en;
        while (!lock_err && n < ATTEMPTS * ATTEMPT_LEN + 50) begin
            cyc();
            n++;
            if (clk_en && !pe) rises++;
            pe = clk_en;
        end
        chk("to_cycle", n, ATTEMPTS * ATTEMPT_LEN + 1);
        chk("to_attempts", rises, ATTEMPTS);
        chk("to_clk_en", clk_en, 0);
        chk("to_running", running, 0);
        cyc();
        chk("to_ready", bus.req_ready, 1);
        repeat (3) cyc();
        chk("to_sticky", lock_err, 1);
        chk("to_mode_sel_held", mode_sel, X2);

        // Any accepted request clears lock_err (off in IDLE is a no-op)
        send(X1, 1'b1);
        chk("clr_lock_err", lock_err, 0);
        chk("clr_ready", bus.req_ready, 1);
        chk("clr_clk_en", clk_en, 0);

        // Lock lands exactly on the terminal count cycle
        send(X2, 1'b0);
        repeat (2 * S + 2 + T - 3) cyc();
        dll = 1'b1;
        repeat (3) cyc();
        chk("bnd_running", running, 1);
        chk("bnd_lock_err", lock_err, 0);

        // Async reset mid-SETTLE
        send(DIV4, 1'b0);
        repeat (10) cyc();
        chk("mid_pre_mode_sel", mode_sel, DIV4);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_clk_en", clk_en, 0);
        chk("mid_rst_mode_sel", mode_sel, X1);
        chk("mid_rst_ready", bus.req_ready, 1);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // Async reset while running
        send(DIV2, 1'b0);
        repeat (2 * S + 3) cyc();
        chk("run_pre_clk_en", clk_en, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("run_rst_clk_en", clk_en, 0);
        chk("run_rst_running", running, 0);
        chk("run_rst_mode_sel", mode_sel, X1);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        chk("glitch_free", glitch, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
